// File: rtl/btn_scan_pkg.sv
// rtl/btn_scan_pkg.sv - shared types and helpers for the scanned button debouncer
package btn_scan_pkg;

  typedef enum logic {IDLE, SCAN} scan_state_t;

  localparam int SYNC_STAGES = 2;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - free-running divider producing a one-cycle strobe every DIV clocks
module tick_prescaler #(
  parameter int DIV = 100_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (count == W'(DIV - 1)) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == W'(DIV - 1));

endmodule

// File: rtl/btn_scan_debouncer.sv
// rtl/btn_scan_debouncer.sv - N-channel debouncer, one shared update path scanned after each tick
// Optional auto-repeat pulses are built when BTN_AUTOREPEAT_EN is defined.
module btn_scan_debouncer
  import btn_scan_pkg::*;
#(
  parameter int N_BTN         = 4,
  parameter int TICK_DIV      = 100_000,
  parameter int STABLE_TICKS  = 10,
  parameter int REPEAT_DELAY  = 500,
  parameter int REPEAT_PERIOD = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat,
  output logic             tick
);

  localparam int CW = cnt_w(STABLE_TICKS);
  localparam int IW = (N_BTN > 1) ? $clog2(N_BTN) : 1;

  logic [SYNC_STAGES-1:0][N_BTN-1:0] sync_q;
  logic [N_BTN-1:0] synced;
  logic [N_BTN-1:0] snap_q, snap_d;
  logic [IW-1:0]    idx_q, idx_d;
  scan_state_t      state_q, state_d;
  logic             slot_en;
  logic [CW-1:0]    cnt_q [N_BTN];

  logic          cur_snap, cur_lvl, differ, flip;
  logic [CW-1:0] cur_cnt, cnt_nxt;

  tick_prescaler #(.DIV(TICK_DIV)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    slot_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick) begin
          snap_d  = synced;
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        slot_en = 1'b1;
        if (idx_q == IW'(N_BTN - 1)) begin
          state_d = IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shared compare/increment path for whichever channel owns the current slot.
  always_comb begin
    cur_snap = snap_q[idx_q];
    cur_lvl  = btn_level[idx_q];
    cur_cnt  = cnt_q[idx_q];
    differ   = (cur_snap != cur_lvl);
    flip     = differ && (cur_cnt == CW'(STABLE_TICKS - 1));
    cnt_nxt  = (differ && !flip) ? cur_cnt + 1'b1 : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      btn_press   <= '0;
      btn_release <= '0;
      if (slot_en) begin
        cnt_q[idx_q] <= cnt_nxt;
        if (flip) begin
          btn_level[idx_q] <= ~cur_lvl;
          if (cur_lvl) begin
            btn_release[idx_q] <= 1'b1;
          end else begin
            btn_press[idx_q] <= 1'b1;
          end
        end
      end
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int HW = cnt_w((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD) + 1;

  logic [HW-1:0]    hold_q [N_BTN];
  logic [HW-1:0]    hold_inc;
  logic [N_BTN-1:0] repeat_q;

  assign hold_inc = hold_q[idx_q] + 1'b1;

  // Once past the initial delay the counter oscillates between DELAY and DELAY+PERIOD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      repeat_q <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        hold_q[i] <= '0;
      end
    end else begin
      repeat_q <= '0;
      if (slot_en) begin
        if (!cur_lvl || flip) begin
          hold_q[idx_q] <= '0;
        end else if (hold_inc == HW'(REPEAT_DELAY + REPEAT_PERIOD)) begin
          hold_q[idx_q]   <= HW'(REPEAT_DELAY);
          repeat_q[idx_q] <= 1'b1;
        end else begin
          hold_q[idx_q] <= hold_inc;
          if (hold_inc == HW'(REPEAT_DELAY)) begin
            repeat_q[idx_q] <= 1'b1;
          end
        end
      end
    end
  end

  assign btn_repeat = repeat_q;
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = (REPEAT_DELAY > 0) ^ (REPEAT_PERIOD > 0);
  assign btn_repeat = '0;
`endif

endmodule

// File: tb/tb_btn_scan_debouncer.sv
// tb/tb_btn_scan_debouncer.sv - self-checking bench for btn_scan_debouncer
module tb_btn_scan_debouncer;

  localparam int NB  = 4;
  localparam int DIV = 8;
  localparam int STB = 3;
  localparam int RD  = 4;
  localparam int RP  = 2;

  logic          clk;
  logic          rst_n;
  logic [NB-1:0] btn_in;
  logic [NB-1:0] btn_level, btn_press, btn_release, btn_repeat;
  logic          tick;

  int nvec = 0;
  int nmis = 0;
  int ecnt;

  btn_scan_debouncer #(
    .N_BTN(NB), .TICK_DIV(DIV), .STABLE_TICKS(STB),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_in      (btn_in),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_repeat  (btn_repeat),
    .tick        (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Active clock edges since the last reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ecnt <= 0;
    else        ecnt <= ecnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: ticks every DIV edges, inputs seen two edges late,
  // channel i judged at edge (tick edge)+1+i, level flips after STB differing samples.
  logic [NB-1:0] m_level, m_press, m_release, m_repeat, m_snap;
  logic          m_tick;
  int            m_edge;
  int            m_run  [NB];
  int            m_held [NB];
  logic [NB-1:0] hist [$];
  logic [NB-1:0] pend_in;
  logic          pend_rst = 1'b0;

  task automatic model_reset();
    m_level = '0; m_press = '0; m_release = '0; m_repeat = '0; m_snap = '0;
    m_tick = 1'b0; m_edge = 0;
    hist.delete();
    for (int i = 0; i < NB; i++) begin
      m_run[i] = 0;
      m_held[i] = 0;
    end
  endtask

  task automatic model_edge(input logic [NB-1:0] smp);
    int ch;
    logic pressed, released;
    m_edge++;
    if (m_edge % DIV == 0) m_snap = (hist.size() >= 2) ? hist[hist.size()-2] : '0;
    hist.push_back(smp);
    if (hist.size() > 4) void'(hist.pop_front());
    m_press = '0; m_release = '0; m_repeat = '0;
    ch = (m_edge % DIV) - 1;
    if (m_edge > DIV && ch >= 0 && ch < NB) begin
      pressed = 1'b0; released = 1'b0;
      if (m_snap[ch] == m_level[ch]) begin
        m_run[ch] = 0;
      end else begin
        m_run[ch]++;
        if (m_run[ch] == STB) begin
          m_run[ch] = 0;
          if (m_level[ch]) released = 1'b1;
          else             pressed = 1'b1;
          m_level[ch] = ~m_level[ch];
        end
      end
      m_press[ch] = pressed;
      m_release[ch] = released;
`ifdef BTN_AUTOREPEAT_EN
      if (pressed || released || !m_level[ch]) begin
        m_held[ch] = 0;
      end else begin
        m_held[ch]++;
        if (m_held[ch] == RD || (m_held[ch] > RD && (m_held[ch] - RD) % RP == 0))
          m_repeat[ch] = 1'b1;
      end
`endif
    end
    m_tick = (m_edge % DIV == DIV - 1);
  endtask

  always @(negedge clk) begin
    if (!rst_n)        model_reset();
    else if (pend_rst) model_edge(pend_in);
    pend_in  = btn_in;
    pend_rst = rst_n;
    chk("model_level",   btn_level,   m_level);
    chk("model_press",   btn_press,   m_press);
    chk("model_release", btn_release, m_release);
    chk("model_repeat",  btn_repeat,  m_repeat);
    chk("model_tick",    tick,        m_tick);
  end

  task automatic at_edge(input int k);
    int guard = 0;
    while (ecnt < k && guard < 2000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (ecnt != k) chk("edge_wait", ecnt, k);
  endtask

  task automatic do_reset(input logic [NB-1:0] v);
    @(posedge clk);
    #1;
    btn_in = v;
    rst_n  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int first_tick, second_tick, npress, first_press;
    rst_n  = 1'b0;
    btn_in = 4'hF;

    // Reset state with all inputs high, then tick period.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_level",   btn_level,   0);
    chk("rst_press",   btn_press,   0);
    chk("rst_release", btn_release, 0);
    chk("rst_repeat",  btn_repeat,  0);
    chk("rst_tick",    tick,        0);
    rst_n = 1'b1;
    first_tick = -1; second_tick = -1;
    for (int e = 1; e <= 20; e++) begin
      at_edge(e);
      if (tick && first_tick < 0) first_tick = e;
      else if (tick && second_tick < 0) second_tick = e;
    end
    chk("tick_first",  first_tick,  7);
    chk("tick_second", second_tick, 15);

    // Clean press on channel 2: level changes at slot 2 of the third scan.
    do_reset(4'h0);
    btn_in = 4'h4;
    at_edge(26);
    chk("clean_level_before", btn_level, 4'h0);
    at_edge(27);
    chk("clean_level", btn_level, 4'h4);
    chk("clean_press", btn_press, 4'h4);
    at_edge(28);
    chk("clean_press_end", btn_press, 4'h0);

    // Bounce on channel 0: toggles every 5 edges for 40 edges, then holds.
    do_reset(4'h0);
    btn_in = 4'h1;
    npress = 0; first_press = -1;
    for (int e = 1; e <= 72; e++) begin
      at_edge(e);
      if (btn_press[0]) begin
        npress++;
        if (first_press < 0) first_press = e;
      end
      btn_in[0] = (e < 40) ? (((e / 5) % 2) == 0) : 1'b1;
    end
    chk("bounce_npress", npress, 1);
    chk("bounce_edge", first_press, 65);
    chk("bounce_level", btn_level, 4'h1);

    // Simultaneous press: pulses staggered one per cycle.
    do_reset(4'h0);
    btn_in = 4'hF;
    at_edge(24);
    chk("simul_level_before", btn_level, 4'h0);
    for (int e = 25; e <= 28; e++) begin
      at_edge(e);
      chk("simul_press", btn_press, 4'h1 << (e - 25));
    end
    chk("simul_level", btn_level, 4'hF);
    at_edge(36);
    btn_in = 4'h0;
    at_edge(70);
    chk("simul_released", btn_level, 4'h0);

    // Reset during scan slot 1 with channel 1 about to flip.
    do_reset(4'h0);
    btn_in = 4'h2;
    at_edge(25);
    rst_n = 1'b0;
    #1;
    chk("midrst_level", btn_level, 4'h0);
    @(posedge clk);
    #1;
    chk("midrst_press", btn_press, 4'h0);
    rst_n = 1'b1;
    at_edge(25);
    chk("midrst_fresh_level", btn_level, 4'h0);
    at_edge(26);
    chk("midrst_fresh_press", btn_press, 4'h2);

`ifdef BTN_AUTOREPEAT_EN
    // Auto-repeat on channel 1, then release.
    at_edge(57);
    chk("rep_none_yet", btn_repeat, 4'h0);
    at_edge(58);
    chk("rep_first", btn_repeat, 4'h2);
    at_edge(74);
    chk("rep_second", btn_repeat, 4'h2);
    btn_in = 4'h0;
    at_edge(130);
    chk("rep_released", btn_level, 4'h0);
`else
    at_edge(90);
    chk("rep_off", btn_repeat, 4'h0);
`endif

    @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
